// File: rtl/dmem_pkg.sv
// Shared types and limits for the wait-state data memory controller.
package dmem_pkg;

  localparam int WAIT_STATES_MAX = 7;
  localparam int CNT_W           = $clog2(WAIT_STATES_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x DATA_W storage: byte-enable synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   addr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [DATA_W/8-1:0]        be_i,
  output logic [DATA_W-1:0]          rdata_o
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_ctrl.sv
// Wait-state data memory controller: one access in flight, accepts back-to-back in RESP.
// Define DMEM_BOUNDS_CHECK_EN to flag out-of-range or misaligned accesses on err_o.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   be_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  stall_o,
  output logic                  err_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam logic MULTI_CYCLE = (WAIT_STATES != 0);

  dmem_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] bank_rdata;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_err;
  logic              accept;

  assign acc_idx = addr_i[OFF_W +: IDX_W];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign acc_err = (addr_i[ADDR_W-1:OFF_W+IDX_W] != '0) || (addr_i[OFF_W-1:0] != '0);
  assign err_o   = done_o & err_q;
`else
  // Upper and byte-offset address bits are ignored: accesses wrap modulo DEPTH.
  logic addr_unused;
  assign addr_unused = ^{addr_i[ADDR_W-1:OFF_W+IDX_W], addr_i[OFF_W-1:0]};
  assign acc_err     = 1'b0;
  assign err_o       = 1'b0;
`endif

  assign ready_o = (state_q != WAIT);
  assign done_o  = (state_q == RESP);
  assign accept  = req_i & ready_o;
  // A zero-wait-state access completes in the very next cycle, so it never holds the pipe.
  assign stall_o = (state_q == WAIT) | (accept & MULTI_CYCLE);

  assign rdata_d = (done_o && !we_q) ? (err_q ? '0 : bank_rdata) : rdata_q;
  assign rdata_o = rdata_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      unique case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            we_q    <= we_i;
            err_q   <= acc_err;
            idx_q   <= acc_idx;
            wdata_q <= wdata_i;
            be_q    <= be_i;
            cnt_q   <= CNT_INIT;
            state_q <= MULTI_CYCLE ? WAIT : RESP;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write commits on the clock edge that ends RESP; a reset beforehand leaves the array untouched.
  dmem_bank #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk    (clk),
    .we_i   (done_o & we_q & ~err_q),
    .addr_i (idx_q),
    .wdata_i(wdata_q),
    .be_i   (be_q),
    .rdata_o(bank_rdata)
  );

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data width in bits (multiple of 8); ADDR_W, default 32, byte-address width; DEPTH, default 64, words (power of 2); WAIT_STATES, default 2, extra access cycles (0..7).
REQ-002 Ports SHALL be: clk  in  1  clock, rising edge; reset  in  1  asynchronous, active-low reset.
REQ-003 Ports SHALL be: req_i  in  1  access request; we_i  in  1  1 = write; addr_i  in  ADDR_W  byte address; wdata_i  in  DATA_W  write data; be_i  in  DATA_W/8  byte enables.
REQ-004 Ports SHALL be: ready_o  out  1  request accepted this cycle if req_i=1; done_o  out  1  access complete pulse; rdata_o  out  DATA_W  read data; stall_o  out  1  pipeline hold; err_o  out  1  access error pulse.

Function
REQ-005 FSM SHALL have states IDLE, WAIT, RESP.
REQ-006 ready_o SHALL be 1 in IDLE and RESP, 0 in WAIT.
REQ-007 Accept (req_i & ready_o) SHALL latch we_i, addr_i, wdata_i, be_i; next state WAIT with counter = WAIT_STATES-1 if WAIT_STATES>0, else RESP.
REQ-008 WAIT SHALL decrement the counter each cycle and move to RESP in the cycle after the counter reaches 0.
REQ-009 Latency SHALL be WAIT_STATES+1 cycles from accept edge to the done_o cycle.
REQ-010 In RESP, done_o=1 for exactly one cycle; writes SHALL commit to the array at the end of RESP, only bytes with be=1 changing.
REQ-011 Reads SHALL drive rdata_o with the addressed word while done_o=1; rdata_o holds its last value otherwise.
REQ-012 Word index SHALL be addr[$clog2(DEPTH)+1:2] (for DATA_W=32); low two address bits ignored.
REQ-013 RESP with req_i=1 SHALL accept the new request (back-to-back, no bubble); RESP with req_i=0 SHALL return to IDLE.
REQ-014 Read immediately following a write to the same word SHALL return the written data.
REQ-015 stall_o SHALL be combinational: 1 when (IDLE or RESP) with req_i=1 and the accepted access is not completing this cycle, or state=WAIT; 0 in the done_o cycle of the last outstanding access.
REQ-016 req_i while ready_o=0 SHALL be ignored; requester holds the request until ready_o=1.

Reset
REQ-017 reset=0 SHALL asynchronously force IDLE, counter 0, done_o=0, err_o=0, rdata_o=0, stall_o=0 registers clear.
REQ-018 Reset mid-access SHALL abort it with no array write; array contents SHALL NOT be reset.

Configuration
REQ-019 With DMEM_BOUNDS_CHECK_EN defined, an access with word index >= DEPTH or addr_i[1:0]!=0 SHALL pulse err_o with done_o, suppress any write, and return rdata_o=0.
REQ-020 Without DMEM_BOUNDS_CHECK_EN, err_o SHALL be tied 0 and out-of-range addresses SHALL wrap modulo DEPTH.

Structure
REQ-021 Package dmem_pkg SHALL hold the FSM state enum and the WAIT_STATES maximum constant.
REQ-022 Storage SHALL be sub-module dmem_bank (DEPTH x DATA_W, byte-enable write, combinational read).

Verification
REQ-023 WAIT_STATES=2: write 0xDEADBEEF to 0x10, be=4'hF -> done_o cycle 3 after accept; read 0x10 -> rdata_o=0xDEADBEEF.
REQ-024 Byte enable: word 0x20=0x11223344, write 0xAABBCCDD be=4'b0101 -> read returns 0x11BB33DD.
REQ-025 Back-to-back: write 0x04=0x5, read 0x04 held on req_i through RESP -> second done_o exactly WAIT_STATES+1 cycles later, rdata_o=0x5, no idle cycle.
REQ-026 WAIT_STATES=0: read each cycle for 4 cycles -> done_o high every cycle, stall_o=0 throughout.
REQ-027 Reset asserted during WAIT of write 0x77 to 0x08 -> IDLE next, done_o never pulses, read 0x08 returns previous content.
REQ-028 DMEM_BOUNDS_CHECK_EN, DEPTH=64: write to 0x100 -> err_o=1 with done_o, array unchanged; read 0x102 -> err_o=1, rdata_o=0.
